// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: valid/ready push side, one-byte-at-a-time
// launch FSM toward uart_tx_en/uart_tx_data, throttled by uart_tx_busy.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          idle,
  output logic          uart_tx_en,
  output logic [7:0]    uart_tx_data,
  input  logic          uart_tx_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT} state_t;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign empty    = (level == '0);
  assign full     = (level == LVL_FULL);
  assign wr_ready = !full;
  assign idle     = empty && (state == S_IDLE) && !uart_tx_busy;

  // Flush suppresses both sides so a same-cycle launch never pops a flushed byte.
  assign push = wr_valid && !full && !flush;
  assign pop  = (state == S_IDLE) && !empty && !uart_tx_busy && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // ARM waits for the transmitter to acknowledge via busy; the pulse is never reissued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      uart_tx_en <= 1'b0;
      case (state)
        S_IDLE: if (pop) begin
          uart_tx_data <= mem[rd_ptr];
          uart_tx_en   <= 1'b1;
          state        <= S_ARM;
        end
        S_ARM:   if (uart_tx_busy)  state <= S_WAIT;
        S_WAIT:  if (!uart_tx_busy) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of pushed bytes versus launch
// pulses, with a behavioural 12 MHz / 115200 baud transmitter supplying busy.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DIV   = 12_000_000 / 115200;
  localparam int BYTE_CYC = 10 * DIV;

  logic          clk = 1'b0;
  logic          reset, flush, wr_valid, wr_ready, empty, full, idle;
  logic          uart_tx_en, uart_tx_busy;
  logic [7:0]    wr_data, uart_tx_data;
  logic [AW:0]   level;

  logic          force_en, force_val;
  logic          m_busy, m_line;
  logic [9:0]    m_sh;
  int            m_cnt, m_bit;

  int            checks = 0;
  int            errors = 0;
  int            pulses = 0;
  int            lvl_max = 0;
  logic          prev_en = 1'b0;
  logic [7:0]    exp_q[$];

  always #5 clk = ~clk;

  assign uart_tx_busy = force_en ? force_val : m_busy;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .level(level), .empty(empty), .full(full), .idle(idle),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy)
  );

  // Transmitter model: latches on uart_tx_en, shifts start, 8 data LSB-first, stop.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_line <= 1'b1; m_sh <= '1; m_cnt <= 0; m_bit <= 0;
    end else if (!m_busy) begin
      if (uart_tx_en) begin
        m_sh <= {1'b1, uart_tx_data, 1'b0};
        m_busy <= 1'b1; m_line <= 1'b0; m_cnt <= 0; m_bit <= 0;
      end
    end else if (m_cnt == DIV - 1) begin
      m_cnt <= 0;
      if (m_bit == 9) m_busy <= 1'b0;
      else begin
        m_bit  <= m_bit + 1;
        m_line <= m_sh[m_bit + 1];
      end
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Every wait goes through here so no launch pulse escapes the scoreboard.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (int'(level) > lvl_max) lvl_max = int'(level);
    if (uart_tx_en === 1'b1) begin
      pulses++;
      checks++;
      if (prev_en === 1'b1) begin
        errors++;
        $display("FAIL en_width: uart_tx_en=1 for 2 cycles, required 1-cycle pulse");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected: launched %02h, required no launch", uart_tx_data);
      end else begin
        e = exp_q.pop_front();
        if (uart_tx_data !== e) begin
          errors++;
          $display("FAIL launch_data: got %02h, required %02h", uart_tx_data, e);
        end
      end
    end
    prev_en = uart_tx_en;
  endtask

  task automatic push_cycle(input logic [7:0] b, output logic acc);
    wr_valid = 1'b1;
    wr_data  = b;
    acc      = wr_ready && !flush;
    tick();
    if (acc) exp_q.push_back(b);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || idle !== 1'b1) && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes pending idle=%b after %0d cycles, required 0 pending idle=1",
               exp_q.size(), idle, bound);
    end
  endtask

  task automatic test_reset();
    logic acc;
    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    force_en = 1'b1; force_val = 1'b0;
    #1;
    checks++;
    if ({uart_tx_en, uart_tx_data, level, empty, full, wr_ready, idle} !==
        {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: en=%b data=%02h level=%0d empty=%b full=%b rdy=%b idle=%b, required 0 00 0 1 0 1 1",
               uart_tx_en, uart_tx_data, level, empty, full, wr_ready, idle);
    end
    tick(); tick();
    reset = 1'b0;
    force_val = 1'b1;
    push_cycle(8'h11, acc); push_cycle(8'h22, acc); push_cycle(8'h33, acc);
    wr_valid = 1'b0;
    force_val = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h11 || level !== 5'd2) begin
      errors++;
      $display("FAIL pre_reset_launch: en=%b data=%02h level=%0d, required 1 11 2", uart_tx_en, uart_tx_data, level);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({uart_tx_en, uart_tx_data, level, empty, wr_ready, idle} !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: en=%b data=%02h level=%0d empty=%b rdy=%b idle=%b, required 0 00 0 1 1 1",
               uart_tx_en, uart_tx_data, level, empty, wr_ready, idle);
    end
    exp_q.delete();
    prev_en = 1'b0;
    tick();
    reset = 1'b0;
    force_en = 1'b0;
  endtask

  task automatic test_single();
    logic acc;
    logic [7:0] got;
    int base = pulses;
    push_cycle(8'hA5, acc);
    wr_valid = 1'b0;
    checks++;
    if (uart_tx_en !== 1'b0 || level !== 5'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_first_edge: en=%b level=%0d empty=%b, required 0 1 0", uart_tx_en, level, empty);
    end
    tick();
    checks++;
    if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_launch: en=%b data=%02h, required 1 a5", uart_tx_en, uart_tx_data);
    end
    tick();
    checks++;
    if (uart_tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: busy=%b, required 1", uart_tx_busy);
    end
    repeat (DIV/2) tick();
    checks++;
    if (m_line !== 1'b0) begin
      errors++;
      $display("FAIL single_start_bit: line=%b, required 0", m_line);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) tick();
      got[i] = m_line;
    end
    checks++;
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL single_line_byte: got %02h, required a5", got);
    end
    repeat (DIV) tick();
    checks++;
    if (m_line !== 1'b1) begin
      errors++;
      $display("FAIL single_stop_bit: line=%b, required 1", m_line);
    end
    wait_drain(300);
    checks++;
    if (pulses - base != 1) begin
      errors++;
      $display("FAIL single_pulse_count: got %0d, required 1", pulses - base);
    end
  endtask

  task automatic test_fill();
    logic acc;
    int base = pulses;
    force_en = 1'b1; force_val = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_cycle(8'(i), acc);
    checks++;
    if (full !== 1'b1 || wr_ready !== 1'b0 || level !== 5'd16) begin
      errors++;
      $display("FAIL fill_full: full=%b rdy=%b level=%0d, required 1 0 16", full, wr_ready, level);
    end
    push_cycle(8'h77, acc);
    wr_valid = 1'b0;
    checks++;
    if (acc !== 1'b0 || level !== 5'd16) begin
      errors++;
      $display("FAIL fill_overflow: accepted=%b level=%0d, required 0 16", acc, level);
    end
    force_en = 1'b0;
    wait_drain(DEPTH * (BYTE_CYC + 10) + 100);
    checks++;
    if (pulses - base != DEPTH) begin
      errors++;
      $display("FAIL fill_pulse_count: got %0d, required %0d", pulses - base, DEPTH);
    end
  endtask

  task automatic test_wrap();
    logic acc;
    int base = pulses;
    lvl_max = 0;
    for (int r = 0; r < 2; r++) begin
      force_en = 1'b1; force_val = 1'b1;
      for (int i = 0; i < 10; i++) push_cycle(8'h40 + 8'(r * 16 + i), acc);
      wr_valid = 1'b0;
      force_en = 1'b0;
      wait_drain(10 * (BYTE_CYC + 10) + 100);
    end
    checks++;
    if (lvl_max != 10 || pulses - base != 20) begin
      errors++;
      $display("FAIL wrap: max level=%0d pulses=%0d, required 10 20", lvl_max, pulses - base);
    end
  endtask

  task automatic test_simul();
    logic acc;
    force_en = 1'b1; force_val = 1'b1;
    for (int i = 0; i < 3; i++) push_cycle(8'h61 + 8'(i), acc);
    force_val = 1'b0;
    push_cycle(8'h64, acc);
    wr_valid = 1'b0;
    checks++;
    if (level !== 5'd3 || uart_tx_en !== 1'b1 || acc !== 1'b1) begin
      errors++;
      $display("FAIL simul_push_pop: level=%0d en=%b accepted=%b, required 3 1 1", level, uart_tx_en, acc);
    end
    force_en = 1'b0;
    wait_drain(4 * (BYTE_CYC + 10) + 100);
    force_en = 1'b1; force_val = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_cycle(8'h80 + 8'(i), acc);
    force_val = 1'b0;
    push_cycle(8'hEE, acc);
    wr_valid = 1'b0;
    checks++;
    if (acc !== 1'b0 || level !== 5'd15 || uart_tx_en !== 1'b1) begin
      errors++;
      $display("FAIL simul_full_pop: accepted=%b level=%0d en=%b, required 0 15 1", acc, level, uart_tx_en);
    end
    force_en = 1'b0;
    wait_drain(DEPTH * (BYTE_CYC + 10) + 100);
  endtask

  task automatic test_flush();
    logic acc;
    int base;
    force_en = 1'b1; force_val = 1'b1;
    push_cycle(8'hC1, acc); push_cycle(8'hC2, acc);
    wr_valid = 1'b0;
    base = pulses;
    force_val = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    repeat (4) tick();
    checks++;
    if (level !== 5'd0 || pulses != base) begin
      errors++;
      $display("FAIL flush_vs_launch: level=%0d pulses=%0d, required 0 0", level, pulses - base);
    end
    force_en = 1'b0;
    base = pulses;
    for (int i = 0; i < 6; i++) push_cycle(8'hD0 + 8'(i), acc);
    wr_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("FAIL flush_prefill: level=%0d, required 5", level);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    checks++;
    if (level !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: level=%0d empty=%b, required 0 1", level, empty);
    end
    wait_drain(BYTE_CYC + 100);
    checks++;
    if (pulses - base != 1) begin
      errors++;
      $display("FAIL flush_pulse_count: got %0d, required 1", pulses - base);
    end
    force_en = 1'b1; force_val = 1'b0;
    base = pulses;
    push_cycle(8'h3C, acc);
    wr_valid = 1'b0;
    repeat (20) tick();
    push_cycle(8'h3D, acc);
    wr_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (pulses - base != 1 || level !== 5'd1) begin
      errors++;
      $display("FAIL stuck_busy_low: pulses=%0d level=%0d, required 1 1", pulses - base, level);
    end
    force_en = 1'b0;
    wait_drain(2 * BYTE_CYC + 100);
    checks++;
    if (pulses - base != 2) begin
      errors++;
      $display("FAIL stuck_release: pulses=%0d, required 2", pulses - base);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simul();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte queue and launch controller directly upstream of the UART transmitter. It accepts bytes from the bus/peripheral side over a valid/ready handshake and stores them in a circular buffer. It hands them one at a time to the transmitter through that block's `uart_tx_en` / `uart_tx_data` / `uart_tx_busy` interface. Software can write a burst of bytes without polling the transmitter between bytes.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, not overridden.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of queued bytes.
- `wr_valid` in 1: producer offers `wr_data`.
- `wr_ready` out 1: FIFO can accept; equals `!full`.
- `wr_data` in 8: byte to enqueue.
- `level` out AW+1: number of queued bytes, 0..DEPTH.
- `empty` out 1: `level == 0`.
- `full` out 1: `level == DEPTH`.
- `idle` out 1: `empty`, FSM in IDLE, and `uart_tx_busy == 0`; all data is on the line.
- `uart_tx_en` out 1: registered one-cycle launch pulse to the transmitter.
- `uart_tx_data` out 8: registered byte presented with `uart_tx_en`.
- `uart_tx_busy` in 1: transmitter busy.

## Operation
- **Storage.** DEPTH×8 array with AW-bit read and write pointers that wrap modulo DEPTH. Occupancy is held in a separate (AW+1)-bit `level` counter.
- **Push.** A push occurs when `wr_valid && wr_ready`. The byte is written at the write pointer, and the pointer increments.
- **Pop.** A pop is performed only by the launch FSM.
- **Level update.** On a push without a pop, `level` +1. On a pop without a push, `level` −1. On a push and pop in the same cycle, `level` is unchanged and both pointers advance.
- **Push when full.** A push is never accepted when full, even if a pop occurs in the same cycle. `wr_ready` is purely `!full`, with no combinational path from the pop.
- **Flush.** `flush` sets both pointers and `level` to 0 and drops any same-cycle push. It does not affect the FSM or a byte already launched. Flush has priority over push and pop.
- **Launch FSM states.**
  - IDLE: if `!empty && !uart_tx_busy`, pop the head into `uart_tx_data`, set `uart_tx_en <= 1`, and go to ARM. Otherwise stay in IDLE.
  - ARM: `uart_tx_en` is high for this cycle only and clears at the next edge. Go to WAIT when `uart_tx_busy == 1`. Otherwise stay in ARM; the pulse is not reissued.
  - WAIT: return to IDLE when `uart_tx_busy == 0`.
- **Pulse width.** `uart_tx_en` is never high for more than one consecutive cycle.
- **Data hold.** `uart_tx_data` holds the last launched byte until the next launch.
- **Flush during launch.** If `flush` and the IDLE launch condition occur in the same cycle, flush wins and no launch occurs.
- **Reset.** All outputs reach their reset values asynchronously when `reset` rises:
  - pointers and `level` = 0
  - FSM = IDLE
  - `uart_tx_en` = 0, `uart_tx_data` = 0x00
  - `empty` = 1, `full` = 0, `wr_ready` = 1
  - `idle` = 1 when `uart_tx_busy` = 0
- **Reset mid-transfer.** A byte being popped is lost. The transmitter is reset separately.

## Timing
- **Flag latency.** A push at edge N makes `level`, `empty` and `full` reflect it after edge N.
- **Launch latency.** Starting with an empty FIFO, IDLE and `!uart_tx_busy`, a push at edge N is followed by a launch decision in cycle N+1 and `uart_tx_en` = 1 in cycle N+2. The transmitter latches the byte at the end of that cycle, and `uart_tx_busy` is high from cycle N+3.
- **Inter-byte gap.** After `uart_tx_busy` falls, the next launch pulse appears 2 cycles later: one cycle for WAIT→IDLE and one for the IDLE decision.
- **Combinational outputs.** `wr_ready`, `empty`, `full` and `idle` are combinational from registers only. No input feeds any output combinationally except `uart_tx_busy`→`idle`.

## Test plan
- **Reset values.** Assert `reset` mid-cycle → `uart_tx_en` = 0, `level` = 0, `empty` = 1, `wr_ready` = 1 immediately, without waiting for a clock.
- **Single byte.** Push 0xA5 with `uart_tx_busy` modelled as a real uart_tx (CLK_FREQ = 12 MHz, BAUD = 115200) → exactly one `uart_tx_en` pulse with `uart_tx_data` = 0xA5, two edges after the push. The line shows start bit, 10100101 LSB-first, then stop bit. `idle` returns to 1.
- **Fill and order.** Push 16 bytes 0x00..0x0F back-to-back while `uart_tx_busy` is forced 1 → `full` = 1 and `wr_ready` = 0 after the 16th byte. A 17th push is refused. After `uart_tx_busy` is released, bytes are emitted in order 0x00..0x0F, one pulse per busy period.
- **Wrap-around.** Push 10, drain 10, push 10 more (pointers wrap) → all 20 bytes emitted in order, with `level` never exceeding 10.
- **Simultaneous push/pop.** Hold `level` = 3, then push in the same cycle as an IDLE launch → `level` stays 3. Also push while full in a pop cycle → push rejected, `level` = 15.
- **Flush.** Queue 5 bytes with `uart_tx_busy` = 1, then pulse `flush` → `level` = 0. The in-flight byte completes and no further `uart_tx_en` pulses occur. A `uart_tx_busy` stuck low after launch keeps the FSM in ARM with no second pulse.
